// File: rtl/addsub_pipe_if.sv
// Operand/result bundle for the pipelined fixed-point adder/subtractor.
// The master side drives operands and enables; the slave side (the datapath)
// returns the quantised result with its valid and overflow flags.
interface addsub_pipe_if #(
    parameter int N_BITS_A   = 9,
    parameter int N_BITS_B   = 9,
    parameter int N_BITS_OUT = 8
);
    logic                  en;
    logic                  in_valid;
    logic [N_BITS_A-1:0]   a;
    logic [N_BITS_B-1:0]   b;
    logic                  sub;
    logic                  out_valid;
    logic [N_BITS_OUT-1:0] sum;
    logic                  ovf;

    modport master (
        output en, in_valid, a, b, sub,
        input  out_valid, sum, ovf
    );

    modport slave (
        input  en, in_valid, a, b, sub,
        output out_valid, sum, ovf
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined signed fixed-point adder/subtractor with output quantisation.
// Operands are aligned to a common binary point and combined at full
// precision, then rounded/truncated to the output format with optional
// saturation. A valid bit and a clock enable travel with the data; data
// registers load only on valid, so the last result is held across bubbles.
module addsub_pipe #(
    parameter int N_BITS_A   = 9,
    parameter int BIN_PT_A   = 6,
    parameter int N_BITS_B   = 9,
    parameter int BIN_PT_B   = 8,
    parameter int N_BITS_OUT = 8,
    parameter int BIN_PT_OUT = 6,
    parameter int ROUND      = 1,
    parameter int SATURATE   = 1,
    parameter int LATENCY    = 2
) (
    input  logic         clk,
    input  logic         rst,
    addsub_pipe_if.slave bus
);

    function automatic int max_int(input int x, input int y);
        if (x > y) begin
            return x;
        end else begin
            return y;
        end
    endfunction

    // Full-precision format: common binary point, widest integer part, one
    // extra bit so that a +/- b can never overflow.
    localparam int BP_F = max_int(BIN_PT_A, BIN_PT_B);
    localparam int WB_F = max_int(N_BITS_A - BIN_PT_A, N_BITS_B - BIN_PT_B);
    localparam int W_F  = WB_F + BP_F + 1;
    localparam int SH_A = BP_F - BIN_PT_A;
    localparam int SH_B = BP_F - BIN_PT_B;

    // Quantised format: either zero-pad the fraction or drop D LSBs.
    localparam bit PAD = (BIN_PT_OUT >= BP_F);
    localparam int D   = PAD ? 0 : (BP_F - BIN_PT_OUT);
    localparam int UP  = PAD ? (BIN_PT_OUT - BP_F) : 0;
    localparam int W_Q = PAD ? (W_F + UP) : (W_F + 1 - D);
    // Comparison width: room for both the quantised value and the bounds.
    localparam int W_C = max_int(W_Q, N_BITS_OUT) + 1;

    localparam logic signed [W_C-1:0] ONE_C = {{(W_C-1){1'b0}}, 1'b1};
    localparam logic signed [W_C-1:0] MAX_V = (ONE_C <<< (N_BITS_OUT - 1)) - ONE_C;
    localparam logic signed [W_C-1:0] MIN_V = ~MAX_V;

    // Output register chain: with LATENCY=1 the quantiser feeds the single
    // output register directly, otherwise stage 1 holds the full-precision sum.
    localparam int NQ = (LATENCY == 1) ? 1 : (LATENCY - 1);

    logic signed [W_F-1:0]        a_al_s;
    logic signed [W_F-1:0]        b_al_s;
    logic signed [W_F-1:0]        full_s;
    logic signed [W_F-1:0]        q_in_s;
    logic                         q_vld_s;
    logic signed [W_Q-1:0]        q_s;
    logic signed [W_C-1:0]        q_c_s;
    logic                         hi_s;
    logic                         lo_s;
    logic [N_BITS_OUT-1:0]        sum_q_s;
    logic                         ovf_q_s;
    logic [NQ-1:0]                vld_r;
    logic [NQ-1:0][N_BITS_OUT-1:0] sum_r;
    logic [NQ-1:0]                ovf_r;

    // Align both operands to BP_F fractional bits and add or subtract exactly.
    always_comb begin
        a_al_s = W_F'($signed(bus.a)) <<< SH_A;
        b_al_s = W_F'($signed(bus.b)) <<< SH_B;
        if (bus.sub) begin
            full_s = a_al_s - b_al_s;
        end else begin
            full_s = a_al_s + b_al_s;
        end
    end

    generate
        if (LATENCY == 1) begin : g_no_s1
            assign q_in_s  = full_s;
            assign q_vld_s = bus.in_valid;
        end else begin : g_s1
            logic signed [W_F-1:0] full_r;
            logic                  v1_r;

            // Stage 1: register the full-precision result when a valid sample is accepted.
            always_ff @(posedge clk) begin
                if (rst) begin
                    full_r <= {W_F{1'b0}};
                    v1_r   <= 1'b0;
                end else if (bus.en) begin
                    v1_r <= bus.in_valid;
                    if (bus.in_valid) begin
                        full_r <= full_s;
                    end
                end
            end

            assign q_in_s  = full_r;
            assign q_vld_s = v1_r;
        end

        if (PAD) begin : g_pad
            assign q_s = W_Q'(q_in_s) <<< UP;
        end else begin : g_drop
            localparam logic [W_F:0] ONE_G = {{W_F{1'b0}}, 1'b1};
            localparam logic [W_F:0] HALF  = (ROUND != 0) ? (ONE_G << (D - 1)) : {(W_F+1){1'b0}};
            logic signed [W_F:0] rnd_s;

            // One guard bit keeps the rounding offset from wrapping at the top.
            assign rnd_s = {q_in_s[W_F-1], q_in_s} + HALF;
            assign q_s   = W_Q'(rnd_s >>> D);
        end
    endgenerate

    assign q_c_s = W_C'(q_s);

    // Range check against the output format and select wrap or clamp.
    always_comb begin
        hi_s    = (q_c_s > MAX_V);
        lo_s    = (q_c_s < MIN_V);
        ovf_q_s = hi_s | lo_s;
        if ((SATURATE != 0) && hi_s) begin
            sum_q_s = MAX_V[N_BITS_OUT-1:0];
        end else if ((SATURATE != 0) && lo_s) begin
            sum_q_s = MIN_V[N_BITS_OUT-1:0];
        end else begin
            sum_q_s = q_c_s[N_BITS_OUT-1:0];
        end
    end

    // Quantised register followed by plain delay stages; data moves only with valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= {NQ{1'b0}};
            sum_r <= {(NQ*N_BITS_OUT){1'b0}};
            ovf_r <= {NQ{1'b0}};
        end else if (bus.en) begin
            vld_r[0] <= q_vld_s;
            if (q_vld_s) begin
                sum_r[0] <= sum_q_s;
                ovf_r[0] <= ovf_q_s;
            end
            for (int i = 1; i < NQ; i++) begin
                vld_r[i] <= vld_r[i-1];
                if (vld_r[i-1]) begin
                    sum_r[i] <= sum_r[i-1];
                    ovf_r[i] <= ovf_r[i-1];
                end
            end
        end
    end

    assign bus.out_valid = vld_r[NQ-1];
    assign bus.sum       = sum_r[NQ-1];
    assign bus.ovf       = ovf_r[NQ-1];

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Pipelined, parametrised signed fixed-point adder/subtractor. It aligns binary points, adds or subtracts per sample, then quantises to a caller-chosen output format with selectable rounding and overflow handling. It carries a valid flag and a clock enable through the pipeline. It is the registered, format-converting replacement for the combinational full-precision adder in datapaths that need a fixed output width.

## Interface
Parameters:
- N_BITS_A, 9: width of `a`, two's complement.
- BIN_PT_A, 6: fractional bits of `a`.
- N_BITS_B, 9: width of `b`.
- BIN_PT_B, 8: fractional bits of `b`.
- N_BITS_OUT, 8: width of `sum`.
- BIN_PT_OUT, 6: fractional bits of `sum`.
- ROUND, 1: 0 = truncate (toward −inf); 1 = round half up (toward +inf on ties).
- SATURATE, 1: 0 = wrap; 1 = clamp to the output range.
- LATENCY, 2: cycles from input to output; legal range 1..8.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  clock enable; 0 freezes every pipeline register.
- in_valid  in  1  `a`, `b` and `sub` are valid this cycle.
- a  in  N_BITS_A  operand A.
- b  in  N_BITS_B  operand B.
- sub  in  1  0 = a+b; 1 = a−b.
- out_valid  out  1  `sum` and `ovf` are valid.
- sum  out  N_BITS_OUT  quantised result, binary point BIN_PT_OUT.
- ovf  out  1  result exceeded the output range; set in both wrap and saturate modes.

## Operation
- Full-precision stage:
  - Fractional bits: BP_F = max(BIN_PT_A, BIN_PT_B).
  - Integer bits: WB_F = max(N_BITS_A−BIN_PT_A, N_BITS_B−BIN_PT_B).
  - Width: W_F = WB_F+BP_F+1.
  - Sign-extend both operands and zero-pad them to BP_F, then compute a±b exactly. Overflow at W_F is impossible.
- Quantise:
  - If BIN_PT_OUT ≥ BP_F, zero-pad the fraction.
  - Otherwise drop D = BP_F−BIN_PT_OUT LSBs.
  - With ROUND=1, add 2^(D−1) before dropping. This addition uses one extra guard bit so it never wraps internally.
- Overflow:
  - Output range is [−2^(N_BITS_OUT−1), 2^(N_BITS_OUT−1)−1] in LSB units.
  - If the quantised value is outside this range, `ovf`=1.
  - SATURATE=1: output the nearest bound (0x7F or 0x80 at defaults).
  - SATURATE=0: output the low N_BITS_OUT bits.
  - A round-up that carries past the maximum counts as overflow.
- Pipeline:
  - Stage 1 registers the full-precision result.
  - Quantise and overflow logic sit between stage 1 and stage 2.
  - Stages 3..LATENCY are plain delay.
  - LATENCY=1: all logic feeds a single output register.
- Each stage carries a valid bit. A stage's data registers load only when its incoming valid=1 and en=1. Otherwise they hold, so `sum`/`ovf` keep the last valid result while out_valid=0.
- Bubbles (in_valid=0) propagate as out_valid=0 and never disturb held data.

## Timing
- Reset (rst=1 at a rising edge), regardless of en:
  - All valid bits, `out_valid`, `sum` and `ovf` become 0 on that edge.
  - Samples in flight are discarded.
  - The first input accepted is the one presented on the first edge with rst=0.
- With en=1 continuously, a sample accepted at edge t appears with out_valid=1 after edge t+LATENCY−1, i.e. visible in cycle t+LATENCY.
- Throughput: one sample per cycle; no backpressure output.
- Each edge with en=0 (and rst=0):
  - Adds exactly one cycle of latency.
  - Holds all outputs, including out_valid.
  - Ignores the inputs.
- Order is preserved; no sample is dropped or duplicated.
- `sub` is sampled with the operands; mixing add and subtract back-to-back is legal.
- Outputs are driven only from registers; there is no combinational input-to-output path.

## Test plan
All scenarios use the default parameters unless stated.
- **Add:** a=0x040 (1.0), b=0x080 (0.5), sub=0 → two cycles later sum=0x60 (1.5), ovf=0, out_valid pulses for one cycle.
- **Overflow:** a=0x0C0 (3.0), b=0x0C0 (0.75), sub=0 → SATURATE=1: sum=0x7F, ovf=1. SATURATE=0: sum=0xF0 (−0.25), ovf=1.
- **Rounding:**
  - a=0, b=0x002 (+1/128): ROUND=1 → sum=0x01; ROUND=0 → sum=0x00.
  - a=0, b=0x1FE (−1/128): ROUND=1 → sum=0x00; ROUND=0 → sum=0xFF.
  - ovf=0 in all four cases.
- **Subtract saturation:** a=0x180 (−2.0), b=0x080 (0.5), sub=1 → sum=0x80, ovf=1.
- **Stall and bubbles:**
  - Stimulus: stream samples 1.0+k/64 for k=0..5 (b=0), with en=0 for 3 cycles mid-stream and one in_valid=0 gap.
  - Required: outputs 0x40..0x45 in order, each exactly once. Outputs and out_valid are frozen during the stall; out_valid=0 for exactly the one bubble cycle.
  - Repeat with LATENCY=1 and LATENCY=5.
- **Reset mid-stream:** assert rst for 1 cycle with 2 samples in flight → the next cycle shows out_valid=0, sum=0, ovf=0. No stale sample emerges. A sample issued on the first post-reset cycle emerges LATENCY cycles later.
